// File: rtl/fxp_pkg.sv
// Shared widths, types and the round/saturate helper for the fixed-point MAC datapath.
package fxp_pkg;

    localparam int INT_W   = 14;
    localparam int FRAC_W  = 12;
    localparam int GUARD_W = 8;

    localparam int W      = INT_W + FRAC_W;
    localparam int PROD_W = 2 * W;
    localparam int ACC_W  = PROD_W + GUARD_W;

    typedef logic signed [W-1:0]      fxp_t;
    typedef logic signed [PROD_W-1:0] prod_t;
    typedef logic signed [ACC_W-1:0]  acc_t;

    // Half an output LSB, expressed in accumulator units (2*FRAC_W fraction bits).
    localparam acc_t ROUND_BIAS = {{(ACC_W-FRAC_W){1'b0}}, 1'b1, {(FRAC_W-1){1'b0}}};

    // Output range limits, sign-extended to accumulator width after the shift.
    localparam acc_t SAT_MAX_ACC = {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam acc_t SAT_MIN_ACC = {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    localparam fxp_t FXP_MAX = {1'b0, {(W-1){1'b1}}};
    localparam fxp_t FXP_MIN = {1'b1, {(W-1){1'b0}}};

    // Round half-up to FRAC_W fraction bits, then clip to the W-bit signed range.
    function automatic fxp_t round_sat(input acc_t acc, output logic sat_flag);
        acc_t biased;
        acc_t shifted;
        fxp_t result;
        biased  = acc + ROUND_BIAS;
        shifted = biased >>> FRAC_W;
        if (shifted > SAT_MAX_ACC) begin
            sat_flag = 1'b1;
            result   = FXP_MAX;
        end else if (shifted < SAT_MIN_ACC) begin
            sat_flag = 1'b1;
            result   = FXP_MIN;
        end else begin
            sat_flag = 1'b0;
            result   = shifted[W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational rounding and saturation of an accumulator value to the result format.
module fxp_round_sat
    import fxp_pkg::*;
(
    input  logic signed [ACC_W-1:0] acc_in,
    output logic signed [W-1:0]     data_out,
    output logic                    sat_out
);

    // Reduce the wide accumulator to a rounded, clipped result word.
    always_comb begin
        sat_out  = 1'b0;
        data_out = round_sat(acc_in, sat_out);
    end

endmodule

// File: rtl/fxp_mac.sv
// Three-stage signed fixed-point multiply-accumulate: multiply, accumulate per packet, round/saturate.
module fxp_mac
    import fxp_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_a,
    input  logic signed [W-1:0] in_b,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_data,
    output logic                out_sat
);

    logic  stall;

    logic  p_valid_q, p_valid_d;
    logic  p_last_q,  p_last_d;
    prod_t p_prod_q,  p_prod_d;

    logic  a_valid_q, a_valid_d;
    logic  a_last_q,  a_last_d;
    acc_t  acc_q,     acc_d;
    logic  first_q,   first_d;

    logic  out_valid_q, out_valid_d;
    fxp_t  out_data_q,  out_data_d;
    logic  out_sat_q,   out_sat_d;

    fxp_t  rs_data;
    logic  rs_sat;

    // A held result freezes the whole pipeline, so acceptance is simply the absence of a stall.
    assign stall     = out_valid_q & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    fxp_round_sat u_round_sat (
        .acc_in   (acc_q),
        .data_out (rs_data),
        .sat_out  (rs_sat)
    );

    // Stage P: capture the full-width product of each accepted operand pair.
    always_comb begin
        p_valid_d = p_valid_q;
        p_last_d  = p_last_q;
        p_prod_d  = p_prod_q;
        if (!stall) begin
            p_valid_d = in_valid;
            p_last_d  = in_valid & in_last;
            p_prod_d  = prod_t'(in_a) * prod_t'(in_b);
        end
    end

    // Stage A: restart the sum on the first beat of a packet, otherwise keep adding; bubbles leave acc alone.
    always_comb begin
        a_valid_d = a_valid_q;
        a_last_d  = a_last_q;
        acc_d     = acc_q;
        first_d   = first_q;
        if (!stall) begin
            a_valid_d = p_valid_q;
            a_last_d  = p_valid_q & p_last_q;
            if (p_valid_q) begin
                acc_d   = (first_q ? acc_t'(0) : acc_q) + acc_t'(p_prod_q);
                first_d = p_last_q;
            end
        end
    end

    // Stage R: load a new result when a packet completes; otherwise the slot empties once not stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (!stall) begin
            if (a_valid_q && a_last_q) begin
                out_valid_d = 1'b1;
                out_data_d  = rs_data;
                out_sat_d   = rs_sat;
            end else begin
                out_valid_d = 1'b0;
            end
        end
    end

    // Stage P registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_valid_q <= 1'b0;
            p_last_q  <= 1'b0;
            p_prod_q  <= '0;
        end else begin
            p_valid_q <= p_valid_d;
            p_last_q  <= p_last_d;
            p_prod_q  <= p_prod_d;
        end
    end

    // Stage A registers; a reset drops any partial packet and arms the next beat as a packet start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid_q <= 1'b0;
            a_last_q  <= 1'b0;
            acc_q     <= '0;
            first_q   <= 1'b1;
        end else begin
            a_valid_q <= a_valid_d;
            a_last_q  <= a_last_d;
            acc_q     <= acc_d;
            first_q   <= first_d;
        end
    end

    // Stage R result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

endmodule

// File: tb/tb_fxp_mac.sv
// Directed self-checking bench for fxp_mac with hand-computed Q14.12 expected values.
module tb_fxp_mac;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [25:0] in_a;
    logic [25:0] in_b;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [25:0] out_data;
    logic        out_sat;

    int vectors;
    int miscompares;

    // Q14.12 operand encodings used throughout the sequence.
    localparam logic [25:0] V_3P25   = 26'h0003400;
    localparam logic [25:0] V_1P5    = 26'h0001800;
    localparam logic [25:0] V_M2P0   = 26'h3FFE000;
    localparam logic [25:0] V_LSB    = 26'h0000001;
    localparam logic [25:0] V_0P5    = 26'h0000800;
    localparam logic [25:0] V_M0P5   = 26'h3FFF800;
    localparam logic [25:0] V_8000   = 26'h1F40000;
    localparam logic [25:0] V_M8000  = 26'h20C0000;
    localparam logic [25:0] V_1P0    = 26'h0001000;
    localparam logic [25:0] V_2P0    = 26'h0002000;
    localparam logic [25:0] V_3P0    = 26'h0003000;
    localparam logic [25:0] V_4P0    = 26'h0004000;
    localparam logic [25:0] V_5P0    = 26'h0005000;

    fxp_mac dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one clock and land 1ns past the rising edge, where outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair and let the next rising edge take it.
    task automatic applyStimulus(input logic [25:0] a, input logic [25:0] b, input logic last);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        tick();
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [25:0] observed, input logic [25:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Wait a bounded number of cycles for a result, check it, then let the handshake consume it.
    task automatic expectResult(input string tag, input logic [25:0] data, input logic sat);
        int n;
        n = 0;
        while (!out_valid && n < 8) begin
            tick();
            n++;
        end
        checkOutput({tag, "_valid"}, {25'd0, out_valid}, 26'd1);
        checkOutput({tag, "_data"}, out_data, data);
        checkOutput({tag, "_sat"}, {25'd0, out_sat}, {25'd0, sat});
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        in_valid    = 1'b0;
        in_a        = '0;
        in_b        = '0;
        in_last     = 1'b0;
        out_ready   = 1'b1;

        // Reset state.
        tick();
        tick();
        checkOutput("reset_in_ready", {25'd0, in_ready}, 26'd1);
        checkOutput("reset_out_valid", {25'd0, out_valid}, 26'd0);
        checkOutput("reset_out_data", out_data, 26'd0);
        checkOutput("reset_out_sat", {25'd0, out_sat}, 26'd0);
        reset_n = 1'b1;
        tick();

        // Single beat 3.25*1.5: result appears on the third edge counting the accepting one.
        applyStimulus(V_3P25, V_1P5, 1'b1);
        idleInputs();
        checkOutput("single_lat1", {25'd0, out_valid}, 26'd0);
        tick();
        checkOutput("single_lat2", {25'd0, out_valid}, 26'd0);
        tick();
        checkOutput("single_valid", {25'd0, out_valid}, 26'd1);
        checkOutput("single_data", out_data, 26'h0004E00);
        checkOutput("single_sat", {25'd0, out_sat}, 26'd0);
        tick();
        checkOutput("single_consumed", {25'd0, out_valid}, 26'd0);

        // Two-beat packet: 4.875 + (-3.0) = 1.875, nothing emitted for the first beat.
        applyStimulus(V_3P25, V_1P5, 1'b0);
        applyStimulus(V_1P5, V_M2P0, 1'b1);
        idleInputs();
        checkOutput("two_beat_no_early", {25'd0, out_valid}, 26'd0);
        tick();
        checkOutput("two_beat_no_early2", {25'd0, out_valid}, 26'd0);
        expectResult("two_beat", 26'h0001E00, 1'b0);

        // Rounding at exactly half an LSB, both signs.
        applyStimulus(V_LSB, V_0P5, 1'b1);
        idleInputs();
        expectResult("round_half_up", 26'h0000001, 1'b0);
        applyStimulus(V_LSB, V_M0P5, 1'b1);
        idleInputs();
        expectResult("round_neg_half", 26'h0000000, 1'b0);

        // Saturation in both directions.
        applyStimulus(V_8000, V_8000, 1'b1);
        idleInputs();
        expectResult("sat_pos", 26'h1FFFFFF, 1'b1);
        applyStimulus(V_8000, V_M8000, 1'b1);
        idleInputs();
        expectResult("sat_neg", 26'h2000000, 1'b1);

        // Bubbles mid-packet: 2.0*1.0, two idle cycles, then 1.0*1.0 -> 3.0.
        applyStimulus(V_2P0, V_1P0, 1'b0);
        idleInputs();
        tick();
        tick();
        applyStimulus(V_1P0, V_1P0, 1'b1);
        idleInputs();
        expectResult("gap", 26'h0003000, 1'b0);

        // Backpressure: three single-beat packets fill the pipe, a fourth waits at the input.
        out_ready = 1'b0;
        applyStimulus(V_1P0, V_2P0, 1'b1);
        checkOutput("bp_ready_early", {25'd0, in_ready}, 26'd1);
        applyStimulus(V_1P0, V_3P0, 1'b1);
        applyStimulus(V_1P0, V_4P0, 1'b1);
        in_valid = 1'b1;
        in_a     = V_1P0;
        in_b     = V_5P0;
        in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_in_ready", {25'd0, in_ready}, 26'd0);
            checkOutput("bp_out_valid", {25'd0, out_valid}, 26'd1);
            checkOutput("bp_hold_data", out_data, V_2P0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {25'd0, in_ready}, 26'd1);
        checkOutput("bp_res0", out_data, V_2P0);
        tick();
        idleInputs();
        checkOutput("bp_res1_valid", {25'd0, out_valid}, 26'd1);
        checkOutput("bp_res1", out_data, V_3P0);
        tick();
        checkOutput("bp_res2_valid", {25'd0, out_valid}, 26'd1);
        checkOutput("bp_res2", out_data, V_4P0);
        tick();
        checkOutput("bp_res3_valid", {25'd0, out_valid}, 26'd1);
        checkOutput("bp_res3", out_data, V_5P0);
        tick();
        checkOutput("bp_drained", {25'd0, out_valid}, 26'd0);

        // Reset mid-packet: beat 1 is already in the accumulator when reset hits.
        applyStimulus(V_1P0, V_1P0, 1'b0);
        idleInputs();
        tick();
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_in_ready", {25'd0, in_ready}, 26'd1);
        checkOutput("midrst_out_valid", {25'd0, out_valid}, 26'd0);
        checkOutput("midrst_out_data", out_data, 26'd0);
        checkOutput("midrst_out_sat", {25'd0, out_sat}, 26'd0);
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        checkOutput("midrst_no_output", {25'd0, out_valid}, 26'd0);
        applyStimulus(V_1P0, V_1P0, 1'b1);
        idleInputs();
        expectResult("post_reset", 26'h0001000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
